// File: rtl/data_mem_responder.sv
// data_mem_responder: memory-side responder for the multicycle CPU.
// Accepts one request at a time, holds it for WAIT_CYCLES wait states,
// then performs a big-endian byte/halfword/word access on an internal
// byte array and pulses ready for one cycle.
module data_mem_responder #(
    parameter int ADDR_WIDTH  = 8,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        busy,
    output logic        misalign
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t                state;
    logic [3:0]            counter;
    logic [ADDR_WIDTH-1:0] a_addr;
    logic                  a_we;
    logic [1:0]            a_size;
    logic [31:0]           a_wdata;

    logic [7:0]            mem [0:DEPTH-1];

    logic [ADDR_WIDTH-1:0] a0, a1, a2, a3;
    logic                  mis;
    logic                  finish;
    logic                  do_write;
    logic [31:0]           rd_word;

    // Upper address bits are deliberately ignored: addresses wrap.
    logic unused_addr_bits;
    assign unused_addr_bits = ^addr[31:ADDR_WIDTH];

    assign a0 = a_addr;
    assign a1 = a_addr + ADDR_WIDTH'(1);
    assign a2 = a_addr + ADDR_WIDTH'(2);
    assign a3 = a_addr + ADDR_WIDTH'(3);

    // Alignment check on the latched request.
    always_comb begin
        mis = 1'b0;
        case (a_size)
            SZ_BYTE: mis = 1'b0;
            SZ_HALF: mis = a_addr[0];
            SZ_WORD: mis = (a_addr[1:0] != 2'b00);
            default: mis = 1'b1;
        endcase
    end

    // The access happens on the edge that raises ready.
    assign finish   = (state == ST_WAIT) && (counter == 4'd0);
    assign do_write = finish && a_we && !mis;

    // Big-endian read assembly, zero-extended.
    always_comb begin
        rd_word = '0;
        case (a_size)
            SZ_BYTE: rd_word = {24'h000000, mem[a0]};
            SZ_HALF: rd_word = {16'h0000, mem[a0], mem[a1]};
            SZ_WORD: rd_word = {mem[a0], mem[a1], mem[a2], mem[a3]};
            default: rd_word = '0;
        endcase
    end

    // Storage write; only the addressed bytes change, contents survive reset.
    always_ff @(posedge clk) begin
        if (do_write) begin
            case (a_size)
                SZ_BYTE: mem[a0] <= a_wdata[7:0];
                SZ_HALF: begin
                    mem[a0] <= a_wdata[15:8];
                    mem[a1] <= a_wdata[7:0];
                end
                SZ_WORD: begin
                    mem[a0] <= a_wdata[31:24];
                    mem[a1] <= a_wdata[23:16];
                    mem[a2] <= a_wdata[15:8];
                    mem[a3] <= a_wdata[7:0];
                end
                default: ;
            endcase
        end
    end

    // Request FSM with registered handshake and read-data outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            counter  <= '0;
            rdata    <= '0;
            ready    <= 1'b0;
            busy     <= 1'b0;
            misalign <= 1'b0;
            a_addr   <= '0;
            a_we     <= 1'b0;
            a_size   <= '0;
            a_wdata  <= '0;
        end else begin
            case (state)
                // RESP doubles as an accept slot so back-to-back requests
                // issue every WAIT_CYCLES+2 cycles; counter is loaded with
                // WAIT_CYCLES (not -1) so ready lands WAIT_CYCLES+1 edges
                // after acceptance.
                ST_IDLE, ST_RESP: begin
                    ready    <= 1'b0;
                    misalign <= 1'b0;
                    if (req) begin
                        a_addr  <= addr[ADDR_WIDTH-1:0];
                        a_we    <= we;
                        a_size  <= size;
                        a_wdata <= wdata;
                        counter <= 4'(WAIT_CYCLES);
                        busy    <= 1'b1;
                        state   <= ST_WAIT;
                    end else begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (counter == 4'd0) begin
                        ready    <= 1'b1;
                        misalign <= mis;
                        if (mis) begin
                            rdata <= '0;
                        end else if (!a_we) begin
                            rdata <= rd_word;
                        end
                        state <= ST_RESP;
                    end else begin
                        counter <= counter - 4'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench for data_mem_responder.
// Main DUT uses WAIT_CYCLES=1; a second instance with WAIT_CYCLES=3
// covers the reset-during-wait case.
module tb_data_mem_responder;

    logic        clk;
    logic        reset, reset3;
    logic        req, req3;
    logic        we;
    logic [1:0]  size;
    logic [31:0] addr, wdata;
    logic [31:0] rdata, rdata3;
    logic        ready, ready3, busy, busy3, misalign, mis3;

    int n_pass  = 0;
    int n_total = 0;

    data_mem_responder #(.ADDR_WIDTH(8), .WAIT_CYCLES(1)) dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .size(size),
        .addr(addr), .wdata(wdata), .rdata(rdata), .ready(ready),
        .busy(busy), .misalign(misalign)
    );

    data_mem_responder #(.ADDR_WIDTH(8), .WAIT_CYCLES(3)) dut3 (
        .clk(clk), .reset(reset3), .req(req3), .we(we), .size(size),
        .addr(addr), .wdata(wdata), .rdata(rdata3), .ready(ready3),
        .busy(busy3), .misalign(mis3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // One complete transaction; lat = edges from acceptance to ready.
    task automatic xfer(input bit d3, input logic wr, input logic [1:0] sz,
                        input logic [31:0] ad, input logic [31:0] wd,
                        output logic [31:0] rd, output logic mis, output int lat);
        @(negedge clk);
        we = wr; size = sz; addr = ad; wdata = wd;
        if (d3) req3 = 1'b1; else req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0; req3 = 1'b0;
        lat = 0;
        while (((d3 ? ready3 : ready) !== 1'b1) && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        rd  = d3 ? rdata3 : rdata;
        mis = d3 ? mis3 : misalign;
    endtask

    initial begin
        logic [31:0] rd;
        logic        mis;
        int          lat;

        reset = 1'b0; reset3 = 1'b0;
        req = 1'b0; req3 = 1'b0; we = 1'b0; size = 2'b00;
        addr = '0; wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_misalign", 32'(misalign), 32'd0);
        chk("rst_rdata", rdata, 32'h0);
        @(negedge clk);
        reset = 1'b1; reset3 = 1'b1;

        // Test 1: reset during WAIT aborts the write (WAIT_CYCLES=3)
        xfer(1, 1'b1, 2'b10, 32'h10, 32'h01020304, rd, mis, lat);
        chk("t1_wr_lat", 32'(lat), 32'd4);
        xfer(1, 1'b0, 2'b10, 32'h10, 32'h0, rd, mis, lat);
        chk("t1_pre_rd", rd, 32'h01020304);
        @(negedge clk);
        we = 1'b1; size = 2'b10; addr = 32'h10; wdata = 32'hDEADBEEF; req3 = 1'b1;
        @(posedge clk); #1;
        req3 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("t1_busy_before", 32'(busy3), 32'd1);
        reset3 = 1'b0;
        #1;
        chk("t1_rst_busy", 32'(busy3), 32'd0);
        chk("t1_rst_ready", 32'(ready3), 32'd0);
        @(negedge clk);
        reset3 = 1'b1;
        xfer(1, 1'b0, 2'b10, 32'h10, 32'h0, rd, mis, lat);
        chk("t1_post_rd", rd, 32'h01020304);

        // Test 2: word write then read
        xfer(0, 1'b1, 2'b10, 32'h20, 32'h11223344, rd, mis, lat);
        chk("t2_wr_lat", 32'(lat), 32'd2);
        chk("t2_wr_mis", 32'(mis), 32'd0);
        chk("t2_wr_rdata_unchanged", rd, 32'h0);
        xfer(0, 1'b0, 2'b10, 32'h20, 32'h0, rd, mis, lat);
        chk("t2_rd_lat", 32'(lat), 32'd2);
        chk("t2_rd_data", rd, 32'h11223344);
        chk("t2_rd_mis", 32'(mis), 32'd0);

        // Test 3: sub-word accesses
        xfer(0, 1'b0, 2'b00, 32'h21, 32'h0, rd, mis, lat);
        chk("t3_lb_21", rd, 32'h00000022);
        xfer(0, 1'b0, 2'b01, 32'h22, 32'h0, rd, mis, lat);
        chk("t3_lh_22", rd, 32'h00003344);
        xfer(0, 1'b1, 2'b00, 32'h23, 32'hFFFFFFAB, rd, mis, lat);
        chk("t3_sb_rdata_hold", rd, 32'h00003344);
        xfer(0, 1'b0, 2'b10, 32'h20, 32'h0, rd, mis, lat);
        chk("t3_lw_20", rd, 32'h112233AB);

        // Test 4: misalignment
        xfer(0, 1'b1, 2'b10, 32'h21, 32'h55667788, rd, mis, lat);
        chk("t4_sw_21_mis", 32'(mis), 32'd1);
        chk("t4_sw_21_rdata", rd, 32'h0);
        xfer(0, 1'b0, 2'b10, 32'h20, 32'h0, rd, mis, lat);
        chk("t4_reload", rd, 32'h112233AB);
        xfer(0, 1'b0, 2'b01, 32'h23, 32'h0, rd, mis, lat);
        chk("t4_lh_23_mis", 32'(mis), 32'd1);
        chk("t4_lh_23_rdata", rd, 32'h0);
        xfer(0, 1'b0, 2'b11, 32'h20, 32'h0, rd, mis, lat);
        chk("t4_sz11_mis", 32'(mis), 32'd1);
        chk("t4_sz11_rdata", rd, 32'h0);
        xfer(0, 1'b0, 2'b10, 32'h20, 32'h0, rd, mis, lat);
        chk("t4_lw_20_intact", rd, 32'h112233AB);
        chk("t4_lw_20_mis", 32'(mis), 32'd0);

        // Test 5: continuous req, alternating addresses; accepts at i=0,3,6,9
        xfer(0, 1'b1, 2'b10, 32'h24, 32'hA5A5A5A5, rd, mis, lat);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            we = 1'b0; size = 2'b10; req = 1'b1;
            addr = (i % 2 == 1) ? 32'h24 : 32'h20;
            @(posedge clk); #1;
            chk($sformatf("t5_ready_%0d", i), 32'(ready), (i % 3 == 2) ? 32'd1 : 32'd0);
            chk($sformatf("t5_busy_%0d", i), 32'(busy), 32'd1);
            if (i % 3 == 2)
                chk($sformatf("t5_rdata_%0d", i), rdata,
                    (i % 6 == 2) ? 32'h112233AB : 32'hA5A5A5A5);
        end
        req = 1'b0;
        @(posedge clk); #1;
        chk("t5_drain_ready", 32'(ready), 32'd0);
        @(posedge clk); #1;
        chk("t5_drain_busy", 32'(busy), 32'd0);

        // Test 6: upper address bits ignored
        xfer(0, 1'b1, 2'b10, 32'h1FC, 32'hCAFEF00D, rd, mis, lat);
        chk("t6_wr_mis", 32'(mis), 32'd0);
        xfer(0, 1'b0, 2'b10, 32'hFC, 32'h0, rd, mis, lat);
        chk("t6_rd_fc", rd, 32'hCAFEF00D);
        chk("t6_rd_mis", 32'(mis), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
